// File: rtl/noise_acq_pkg.sv
// -----------------------------------------------------------------------------
// noise_acq_pkg
// Shared definitions for the noise-acquisition read path.
//
// Contents:
//   SAMPLE_W / ADDR_W / XD_W  : ADC sample, DSP address and DSP data widths
//   ADDR_DATA_DEF / _STAT_DEF : default DSP read addresses
//   STAT_*                    : bit positions inside the status word
//   ENTRY_W                   : width of one FIFO entry (sample, plus tag if enabled)
//   acq_state_t               : acquisition FSM states (IDLE / ACQ / DONE)
//   sat_count / pack_status   : status-word helpers
//
// Build option: define NOISE_ACQ_TAG_EN to store a 4-bit per-window sample tag
// alongside every sample. It is returned in the upper nibble of the data word.
// -----------------------------------------------------------------------------
package noise_acq_pkg;

    localparam int SAMPLE_W = 12;
    localparam int ADDR_W   = 19;
    localparam int XD_W     = 16;
    localparam int TAG_W    = 4;

    localparam logic [ADDR_W-1:0] ADDR_DATA_DEF = 19'h000A0;
    localparam logic [ADDR_W-1:0] ADDR_STAT_DEF = 19'h000A1;

    // Status word layout: {overflow, full, empty, data_ready, 1'b0, count[10:0]}
    localparam int STAT_OVF_BIT   = 15;
    localparam int STAT_FULL_BIT  = 14;
    localparam int STAT_EMPTY_BIT = 13;
    localparam int STAT_RDY_BIT   = 12;
    localparam int STAT_CNT_W     = 11;

`ifdef NOISE_ACQ_TAG_EN
    localparam int ENTRY_W = TAG_W + SAMPLE_W;
`else
    localparam int ENTRY_W = SAMPLE_W;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        DONE = 2'd2
    } acq_state_t;

    // The status field is 11 bits wide; larger counts read back as 2047.
    function automatic logic [STAT_CNT_W-1:0] sat_count(input logic [31:0] cnt);
        logic [STAT_CNT_W-1:0] res;
        if (cnt > 32'd2047) begin
            res = '1;
        end else begin
            res = cnt[STAT_CNT_W-1:0];
        end
        return res;
    endfunction

    function automatic logic [XD_W-1:0] pack_status(
        input logic                  ovf,
        input logic                  full,
        input logic                  empty,
        input logic                  rdy,
        input logic [STAT_CNT_W-1:0] cnt
    );
        logic [XD_W-1:0] w;
        w                 = '0;
        w[STAT_OVF_BIT]   = ovf;
        w[STAT_FULL_BIT]  = full;
        w[STAT_EMPTY_BIT] = empty;
        w[STAT_RDY_BIT]   = rdy;
        w[STAT_CNT_W-1:0] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/noise_acq_reader_fifo.sv
// -----------------------------------------------------------------------------
// noise_sample_fifo
// Single-clock sample FIFO with synchronous flush. The head entry is visible
// combinationally on rd_data. A push into a full FIFO is accepted only when a
// pop happens in the same cycle. Pops of an empty FIFO are ignored.
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   flush            : empty the FIFO (wins over push/pop in the same cycle)
//   push, wr_data    : write request and data
//   pop              : advance the head
//   rd_data          : current head entry
//   full, empty      : occupancy flags
//   count            : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module noise_sample_fifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the one the pop frees.
    assign do_push = push & (~full | do_pop);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset. The pointers and count alone decide
    // which entries are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/noise_acq_reader.sv
// -----------------------------------------------------------------------------
// noise_acq_reader
// Captures 12-bit ADC noise samples into a FIFO during an acquisition window.
// It then returns the samples and a status word to the DSP over its
// asynchronous read bus. The enclosing top level drives the xd pads from
// xd_out/xd_oe.
//
// Ports:
//   clk        : 40 MHz system clock
//   reset      : asynchronous active-high reset; clears all state
//   acq_en     : acquisition window level from the noise state machine
//   acq_tick   : one-clk sample strobe; adc_data is valid while it is high
//   adc_data   : 12-bit ADC sample
//   zcs2, xrd  : DSP chip select and read strobe, active-low, asynchronous
//   xa         : DSP address, stable while xrd is low
//   xd_out     : read data, latched at the start of each decoded read
//   xd_oe      : pad drive enable, high for the duration of a decoded read
//   data_ready : window closed and unread samples remain
//   overflow   : sticky; a sample was dropped because the FIFO was full
//
// Build option: define NOISE_ACQ_TAG_EN to tag each sample with the low 4 bits
// of a per-window accepted-sample counter. The tag is returned as data[15:12].
// -----------------------------------------------------------------------------
module noise_acq_reader
    import noise_acq_pkg::*;
#(
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] ADDR_DATA = ADDR_DATA_DEF,
    parameter logic [ADDR_W-1:0] ADDR_STAT = ADDR_STAT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                acq_en,
    input  logic                acq_tick,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                zcs2,
    input  logic                xrd,
    input  logic [ADDR_W-1:0]   xa,
    output logic [XD_W-1:0]     xd_out,
    output logic                xd_oe,
    output logic                data_ready,
    output logic                overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // ---------------------------------------------------------------- state
    logic                zcs2_m_q, zcs2_m_d, zcs2_s_q, zcs2_s_d;
    logic                xrd_m_q,  xrd_m_d,  xrd_s_q,  xrd_s_d;
    logic [ADDR_W-1:0]   xa_q,     xa_d;
    logic                rd_act_q, rd_act_d;
    logic [XD_W-1:0]     xd_out_q, xd_out_d;
    logic                acq_en_q, acq_en_d;
    logic                overflow_q, overflow_d;
    acq_state_t          state_q,  state_d;
`ifdef NOISE_ACQ_TAG_EN
    logic [TAG_W-1:0]    tag_cnt_q, tag_cnt_d;
`endif

    // ----------------------------------------------------------- comb nets
    logic                rd_sel, rd_sel_next;
    logic                hit_data, hit_stat;
    logic                rd_act, rd_start, rd_end;
    logic                acq_rise;
    logic                flush, push_req, push_ok, ovf_set, fifo_pop;
    logic [ENTRY_W-1:0]  fifo_wr_data, fifo_rd_data;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [XD_W-1:0]     data_word, stat_word;

    // ------------------------------------------------------------- FIFO
    noise_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push_ok),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef NOISE_ACQ_TAG_EN
    assign fifo_wr_data = {tag_cnt_q, adc_data};
    assign data_word    = fifo_rd_data;
`else
    assign fifo_wr_data = adc_data;
    assign data_word    = {4'h0, fifo_rd_data};
`endif

    // -------------------------------------------------- bus decode and latch
    always_comb begin
        zcs2_m_d = zcs2;
        zcs2_s_d = zcs2_m_q;
        xrd_m_d  = xrd;
        xrd_s_d  = xrd_m_q;

        rd_sel      = ~zcs2_s_q & ~xrd_s_q;
        // rd_sel_next is the value rd_sel takes at the next edge. xa is
        // captured on the edge where the synchronized read goes active.
        rd_sel_next = ~zcs2_m_q & ~xrd_m_q;
        xa_d        = (rd_sel_next && !rd_sel) ? xa : xa_q;

        hit_data = (xa_q == ADDR_DATA);
        hit_stat = (xa_q == ADDR_STAT);
        rd_act   = rd_sel & (hit_data | hit_stat);
        rd_act_d = rd_act;
        rd_start = rd_act & ~rd_act_q;
        rd_end   = ~rd_act & rd_act_q;

        // xa_q still holds the finished read's address in the rd_end cycle.
        fifo_pop = rd_end & hit_data & ~fifo_empty;

        stat_word = pack_status(overflow_q, fifo_full, fifo_empty, data_ready,
                                sat_count(32'(fifo_count)));

        xd_out_d = xd_out_q;
        if (rd_start) begin
            if (hit_data) begin
                xd_out_d = fifo_empty ? '0 : data_word;
            end else begin
                xd_out_d = stat_word;
            end
        end
    end

    // ------------------------------------------------------ acquisition path
    always_comb begin
        acq_en_d = acq_en;
        acq_rise = acq_en & ~acq_en_q;

        ok_push_calc: begin
            // A push into a full FIFO is accepted only alongside a pop.
            push_ok = push_req & (~fifo_full | fifo_pop);
            ovf_set = push_req & fifo_full & ~fifo_pop;
        end

        overflow_d = flush ? 1'b0 : (overflow_q | ovf_set);
`ifdef NOISE_ACQ_TAG_EN
        tag_cnt_d = tag_cnt_q;
        if (flush) begin
            tag_cnt_d = '0;
        end else if (push_ok) begin
            tag_cnt_d = tag_cnt_q + 4'd1;
        end
`endif
    end

    // ------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (acq_rise) state_d = ACQ;
            ACQ:  if (!acq_en)  state_d = DONE;
            DONE: begin
                // A new window discards any unread data from the previous one.
                if (acq_rise) begin
                    state_d = ACQ;
                end else if (fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush      = acq_rise & (state_q != ACQ);
        push_req   = acq_tick & (state_q == ACQ);
        data_ready = (state_q == DONE) & ~fifo_empty;
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zcs2_m_q   <= 1'b1;
            zcs2_s_q   <= 1'b1;
            xrd_m_q    <= 1'b1;
            xrd_s_q    <= 1'b1;
            xa_q       <= '0;
            rd_act_q   <= 1'b0;
            xd_out_q   <= '0;
            acq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
`ifdef NOISE_ACQ_TAG_EN
            tag_cnt_q  <= '0;
`endif
        end else begin
            zcs2_m_q   <= zcs2_m_d;
            zcs2_s_q   <= zcs2_s_d;
            xrd_m_q    <= xrd_m_d;
            xrd_s_q    <= xrd_s_d;
            xa_q       <= xa_d;
            rd_act_q   <= rd_act_d;
            xd_out_q   <= xd_out_d;
            acq_en_q   <= acq_en_d;
            overflow_q <= overflow_d;
`ifdef NOISE_ACQ_TAG_EN
            tag_cnt_q  <= tag_cnt_d;
`endif
        end
    end

    // xd_oe comes straight from a flop with an asynchronous reset, so a reset
    // in the middle of a read releases the pads at once.
    assign xd_oe    = rd_act_q;
    assign xd_out   = xd_out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_noise_acq_reader.sv
// -----------------------------------------------------------------------------
// tb_noise_acq_reader
// Scoreboard bench for noise_acq_reader. Each read pushes the word the DSP
// should see, taken from a queue model of the FIFO, onto exp_q. The entry is
// popped and compared when xd_oe shows the DUT driving the bus.
// -----------------------------------------------------------------------------
module tb_noise_acq_reader;
    import noise_acq_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LOW_W = 6;   // xrd low time in clk periods

    logic                clk = 1'b0;
    logic                reset;
    logic                acq_en;
    logic                acq_tick;
    logic [SAMPLE_W-1:0] adc_data;
    logic                zcs2;
    logic                xrd;
    logic [ADDR_W-1:0]   xa;
    logic [XD_W-1:0]     xd_out;
    logic                xd_oe;
    logic                data_ready;
    logic                overflow;

    noise_acq_reader #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .acq_en     (acq_en),
        .acq_tick   (acq_tick),
        .adc_data   (adc_data),
        .zcs2       (zcs2),
        .xrd        (xrd),
        .xa         (xa),
        .xd_out     (xd_out),
        .xd_oe      (xd_oe),
        .data_ready (data_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------- model
    logic [15:0] m_q[$];      // expected FIFO contents as returned data words
    logic [15:0] exp_q[$];    // scoreboard of pending read results
    bit          m_ovf;
    bit          m_done;      // window closed
    bit          m_acq;       // window open
    logic [3:0]  m_tag;

    function automatic logic [15:0] m_word(input logic [11:0] s);
`ifdef NOISE_ACQ_TAG_EN
        return {m_tag, s};
`else
        return {4'h0, s};
`endif
    endfunction

    function automatic logic [15:0] m_expect(input logic [18:0] addr);
        int cnt;
        cnt = m_q.size();
        if (addr == ADDR_DATA_DEF) begin
            return (cnt == 0) ? 16'h0000 : m_q[0];
        end
        return {m_ovf, cnt == DEPTH, cnt == 0, m_done && cnt != 0, 1'b0, 11'(cnt)};
    endfunction

    task automatic m_push(input logic [11:0] v);
        if (m_acq) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(m_word(v));
                m_tag++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // --------------------------------------------------------- stimulus
    task automatic tick(input logic [11:0] v);
        @(negedge clk);
        acq_tick = 1'b1;
        adc_data = v;
        m_push(v);
        @(negedge clk);
        acq_tick = 1'b0;
    endtask

    task automatic window_open();
        @(negedge clk);
        acq_en = 1'b1;
        m_q.delete();
        m_ovf  = 1'b0;
        m_tag  = 4'h0;
        m_acq  = 1'b1;
        m_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic window_close();
        @(negedge clk);
        acq_en = 1'b0;
        m_acq  = 1'b0;
        m_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    // One DSP read. With tick_end set, acq_tick is raised for the single cycle
    // in which the DUT sees the read end, so push and pop coincide.
    task automatic do_read(input string tag, input logic [18:0] addr,
                           input bit tick_end, input logic [11:0] tick_val);
        logic [15:0] got;
        logic [15:0] exp;
        bit          seen;
        int          hi;
        exp_q.push_back(m_expect(addr));
        got  = '0;
        seen = 1'b0;
        hi   = 0;
        @(negedge clk);
        zcs2 = 1'b0;
        xrd  = 1'b0;
        xa   = addr;
        for (int i = 0; i < LOW_W; i++) begin
            @(negedge clk);
            if (xd_oe) begin
                hi++;
                if (!seen) begin
                    seen = 1'b1;
                    got  = xd_out;
                end
            end
        end
        zcs2 = 1'b1;
        xrd  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (xd_oe) hi++;
            if (tick_end && i == 1) begin
                acq_tick = 1'b1;
                adc_data = tick_val;
            end
            if (tick_end && i == 2) acq_tick = 1'b0;
        end
        exp = exp_q.pop_front();
        check({tag, "_oe_seen"}, 32'(seen), 32'd1);
        check(tag, 32'(got), 32'(exp));
        check({tag, "_oe_width"}, 32'(hi >= LOW_W - 1 && hi <= LOW_W + 1), 32'd1);
        if (addr == ADDR_DATA_DEF && m_q.size() > 0) void'(m_q.pop_front());
        if (tick_end) m_push(tick_val);
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        reset    = 1'b1;
        acq_en   = 1'b0;
        acq_tick = 1'b0;
        adc_data = '0;
        zcs2     = 1'b1;
        xrd      = 1'b1;
        xa       = '0;
        m_ovf    = 1'b0;
        m_done   = 1'b0;
        m_acq    = 1'b0;
        m_tag    = 4'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_xd_out", 32'(xd_out), 32'h0);
        check("rst_xd_oe", 32'(xd_oe), 32'h0);
        check("rst_rdy", 32'(data_ready), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        do_read("stat_after_rst", ADDR_STAT_DEF, 1'b0, '0);

        // Six-sample window
        window_open();
        for (int i = 0; i < 6; i++) tick(12'(32'h123 + i));
        window_close();
        check("rdy_after_close", 32'(data_ready), 32'd1);
        for (int i = 0; i < 6; i++) do_read("rd6", ADDR_DATA_DEF, 1'b0, '0);
        check("rdy_after_6", 32'(data_ready), 32'd0);
        do_read("rd_empty", ADDR_DATA_DEF, 1'b0, '0);

        // Overflow: 1030 samples into 1024 slots
        window_open();
        for (int i = 0; i < 1030; i++) tick(12'(i + 1));
        check("ovf_pin", 32'(overflow), 32'd1);
        window_close();
        do_read("stat_ovf", ADDR_STAT_DEF, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) do_read("rd_full", ADDR_DATA_DEF, 1'b0, '0);
        do_read("stat_drained", ADDR_STAT_DEF, 1'b0, '0);

        // Push coincident with the pop that ends a read of a full FIFO
        window_open();
        for (int i = 0; i < DEPTH; i++) tick(12'(i + 7));
        do_read("rd_coinc", ADDR_DATA_DEF, 1'b1, 12'hABC);
        do_read("stat_coinc", ADDR_STAT_DEF, 1'b0, '0);
        check("ovf_coinc", 32'(overflow), 32'd0);
        tick(12'h555);
        check("ovf_extra", 32'(overflow), 32'd1);
        window_close();
        check("rdy_full", 32'(data_ready), 32'd1);
        window_open();
        check("ovf_cleared", 32'(overflow), 32'd0);
        do_read("stat_flush_full", ADDR_STAT_DEF, 1'b0, '0);
        window_close();

        // New window in DONE with three unread samples
        window_open();
        for (int i = 0; i < 3; i++) tick(12'(32'h0A0 + i));
        window_close();
        check("rdy_3", 32'(data_ready), 32'd1);
        window_open();
        check("rdy_flushed", 32'(data_ready), 32'd0);
        do_read("stat_flush3", ADDR_STAT_DEF, 1'b0, '0);
        window_close();

        // Tag nibble (zero in the default build)
        window_open();
        for (int i = 0; i < 18; i++) tick(12'(32'h300 + i));
        window_close();
        for (int i = 0; i < 18; i++) do_read("rd_tag", ADDR_DATA_DEF, 1'b0, '0);

        // Reset in the middle of a read
        window_open();
        tick(12'h111);
        tick(12'h222);
        window_close();
        @(negedge clk);
        zcs2 = 1'b0;
        xrd  = 1'b0;
        xa   = ADDR_DATA_DEF;
        repeat (4) @(negedge clk);
        check("oe_before_rst", 32'(xd_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("oe_async_drop", 32'(xd_oe), 32'd0);
        check("rdy_async_drop", 32'(data_ready), 32'd0);
        @(negedge clk);
        zcs2 = 1'b1;
        xrd  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_acq  = 1'b0;
        do_read("stat_after_midrst", ADDR_STAT_DEF, 1'b0, '0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
